// File: rtl/mult_div_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mult_div_unit: iterative 32-cycle MULT/MULTU/DIV/DIVU with HI/LO regs.   |
// | Optional signed ops built when MULTDIV_SIGNED_EN is defined.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mult_div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        mthi_we,
  input  logic        mtlo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      r_state, w_state_next;
  logic [4:0]  r_cnt;
  logic        r_is_div;
  logic [31:0] r_opnd;      // multiplicand or divisor magnitude
  logic [63:0] r_work;      // {acc, multiplier} or {remainder, quotient}
  logic        r_done, r_dbz;
  logic [31:0] r_hi, r_lo;
  logic        w_accept, w_last;
  logic [32:0] w_sum, w_trial;
  logic [63:0] w_work_next;
  logic [31:0] w_hi_res, w_lo_res;
  logic [31:0] w_a_mag, w_b_mag;

`ifdef MULTDIV_SIGNED_EN
  logic        r_res_neg, r_rem_neg;
  logic [31:0] r_a_raw;
  logic        w_signed;
  assign w_signed = op[0];
  assign w_a_mag  = (w_signed && src_a[31]) ? -src_a : src_a;
  assign w_b_mag  = (w_signed && src_b[31]) ? -src_b : src_b;
`else
  logic        w_unused_op;
  assign w_unused_op = op[0];
  assign w_a_mag     = src_a;
  assign w_b_mag     = src_b;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: if (start) begin
        w_accept     = 1'b1;
        w_state_next = RUN;
      end
      RUN: if (r_cnt == 5'd31) begin
        w_last       = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // One iteration: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    w_sum   = {1'b0, r_work[63:32]} + (r_work[0] ? {1'b0, r_opnd} : 33'd0);
    w_trial = r_work[63:31] - {1'b0, r_opnd};
    if (r_is_div)
      w_work_next = w_trial[32] ? {r_work[62:0], 1'b0}
                                : {w_trial[31:0], r_work[30:0], 1'b1};
    else
      w_work_next = {w_sum, r_work[31:1]};
  end

  always_comb begin
    w_hi_res = w_work_next[63:32];
    w_lo_res = w_work_next[31:0];
`ifdef MULTDIV_SIGNED_EN
    if (!r_is_div) begin
      if (r_res_neg) {w_hi_res, w_lo_res} = -w_work_next;
    end else if (r_opnd == 32'd0) begin
      w_lo_res = 32'hFFFF_FFFF;
      w_hi_res = r_a_raw;
    end else begin
      if (r_res_neg) w_lo_res = -w_work_next[31:0];
      if (r_rem_neg) w_hi_res = -w_work_next[63:32];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= 5'd0;
      r_is_div <= 1'b0;
      r_opnd   <= 32'd0;
      r_work   <= 64'd0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
`ifdef MULTDIV_SIGNED_EN
      r_res_neg <= 1'b0;
      r_rem_neg <= 1'b0;
      r_a_raw   <= 32'd0;
`endif
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_cnt    <= 5'd0;
        r_is_div <= op[1];
        r_opnd   <= op[1] ? w_b_mag : w_a_mag;
        r_work   <= {32'd0, op[1] ? w_a_mag : w_b_mag};
`ifdef MULTDIV_SIGNED_EN
        r_res_neg <= w_signed & (src_a[31] ^ src_b[31]);
        r_rem_neg <= w_signed & src_a[31];
        r_a_raw   <= src_a;
`endif
      end else if (r_state == RUN) begin
        r_work <= w_work_next;
        r_cnt  <= r_cnt + 5'd1;
        if (w_last) begin
          r_hi  <= w_hi_res;
          r_lo  <= w_lo_res;
          r_dbz <= r_is_div && (r_opnd == 32'd0);
        end
      end else begin
        if (mthi_we) r_hi <= wdata;
        if (mtlo_we) r_lo <= wdata;
      end
    end
  end

  assign busy        = (r_state == RUN);
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mult_div_unit: vector table, hand sequences and random ops vs model.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mult_div_unit;

`ifdef MULTDIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = 32'd0, src_b = 32'd0;
  logic        mthi_we = 1'b0, mtlo_we = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_hi = 32'd0, exp_lo = 32'd0;

  mult_div_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .mthi_we(mthi_we), .mtlo_we(mtlo_we),
    .wdata(wdata), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dbz;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference from arithmetic: 64-bit integer multiply / divide.
  function automatic void model(input logic [1:0] mop, input logic [31:0] a, b,
                                output logic [31:0] mhi, mlo, output logic mdbz);
    longint sa, sb, q, r;
    logic [63:0] p;
    bit sgn;
    sgn  = SIGNED_EN && mop[0];
    sa   = sgn ? longint'($signed(a)) : longint'(a);
    sb   = sgn ? longint'($signed(b)) : longint'(b);
    mdbz = 1'b0;
    if (!mop[1]) begin
      p = sa * sb;
      mhi = p[63:32];
      mlo = p[31:0];
    end else if (b == 32'd0) begin
      mlo = 32'hFFFF_FFFF;
      mhi = a;
      mdbz = 1'b1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      mlo = q[31:0];
      mhi = r[31:0];
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] iop, input logic [31:0] a, b);
    start = 1'b1; op = iop; src_a = a; src_b = b;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int cyc);
    bit early_idle;
    cyc = 0;
    early_idle = 1'b0;
    while (cyc < 40) begin
      tick();
      cyc++;
      if (done) break;
      if (!busy) early_idle = 1'b1;
    end
    check({name, "_latency"}, 64'(cyc), 64'd32);
    check({name, "_busy_held"}, {63'd0, early_idle}, 64'd0);
    check({name, "_busy_at_done"}, {63'd0, busy}, 64'd0);
  endtask

  task automatic run_check(input string name, input logic [1:0] iop, input logic [31:0] a, b,
                           input logic [31:0] rhi, rlo, input logic rdbz);
    int cyc;
    issue(iop, a, b);
    wait_done(name, cyc);
    check({name, "_hilo"}, {hi, lo}, {rhi, rlo});
    check({name, "_dbz"}, {63'd0, div_by_zero}, {63'd0, rdbz});
    exp_hi = rhi;
    exp_lo = rlo;
  endtask

  initial begin
    vec_t vecs[$];
    logic [31:0] mh, ml;
    logic md;
    int cyc, ndone, done_at;
    logic [31:0] ra, rb;
    logic [1:0] rop;

    vecs.push_back('{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0});
    vecs.push_back('{2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0});
    vecs.push_back('{2'b10, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, 1'b1});
    vecs.push_back('{2'b00, 32'd0, 32'hDEAD_BEEF, 32'd0, 32'd0, 1'b0});
    vecs.push_back('{2'b11, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b1});
`ifdef MULTDIV_SIGNED_EN
    vecs.push_back('{2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0});
    vecs.push_back('{2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0});
    vecs.push_back('{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0});
`else
    vecs.push_back('{2'b01, 32'hFFFF_FFFD, 32'd7, 32'd6, 32'hFFFF_FFEB, 1'b0});
    vecs.push_back('{2'b11, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC, 1'b0});
    vecs.push_back('{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0});
`endif

    tick();
    tick();
    rst_n = 1'b1;
    check("reset_state", {busy, done, div_by_zero, hi, lo}, 67'd0);

    mtlo_we = 1'b1; wdata = 32'h5A5A_5A5A;
    tick();
    mtlo_we = 1'b0;
    check("mtlo_idle", {hi, lo}, {32'd0, 32'h5A5A_5A5A});
    mthi_we = 1'b1; mtlo_we = 1'b1; wdata = 32'h1357_9BDF;
    tick();
    mthi_we = 1'b0; mtlo_we = 1'b0;
    check("mthi_mtlo_both", {hi, lo}, {32'h1357_9BDF, 32'h1357_9BDF});
    exp_hi = 32'h1357_9BDF; exp_lo = 32'h1357_9BDF;

    foreach (vecs[i])
      run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].hi, vecs[i].lo, vecs[i].dbz);

    // start pulses at RUN cycles 5 and 31 must be dropped
    issue(2'b00, 32'h0001_2345, 32'h0006_789A);
    ndone = 0; done_at = 0;
    for (int k = 1; k <= 40; k++) begin
      start = (k == 5 || k == 31); op = 2'b10; src_a = 32'd99; src_b = 32'd3;
      tick();
      start = 1'b0;
      if (done) begin ndone++; done_at = k; end
    end
    model(2'b00, 32'h0001_2345, 32'h0006_789A, mh, ml, md);
    check("ignore_start_ndone", 64'(ndone), 64'd1);
    check("ignore_start_at", 64'(done_at), 64'd32);
    check("ignore_start_hilo", {hi, lo}, {mh, ml});
    check("ignore_start_idle", {63'd0, busy}, 64'd0);
    exp_hi = mh; exp_lo = ml;

    // mthi in RUN is ignored; HI/LO hold until completion
    issue(2'b00, 32'h0000_BEEF, 32'h0000_CAFE);
    model(2'b00, 32'h0000_BEEF, 32'h0000_CAFE, mh, ml, md);
    ndone = 0;
    for (int k = 1; k <= 40; k++) begin
      mthi_we = (k == 10); wdata = 32'hAAAA_5555;
      tick();
      mthi_we = 1'b0;
      if (k == 20) check("hold_during_run", {hi, lo}, {exp_hi, exp_lo});
      if (done) begin ndone++; break; end
    end
    check("mthi_run_done", 64'(ndone), 64'd1);
    check("mthi_run_hilo", {hi, lo}, {mh, ml});
    exp_hi = mh; exp_lo = ml;

    // start and mthi in the same cycle: start wins
    mthi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    issue(2'b10, 32'd1000, 32'd33);
    mthi_we = 1'b0;
    check("start_wins_hi", {32'd0, hi}, {32'd0, exp_hi});
    wait_done("start_wins", cyc);
    check("start_wins_hilo", {hi, lo}, {32'd10, 32'd30});
    exp_hi = 32'd10; exp_lo = 32'd30;

    // reset at RUN cycle 10 aborts the operation
    issue(2'b00, 32'h0F0F_0F0F, 32'h1234_5678);
    for (int k = 1; k < 10; k++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midreset_state", {busy, done, div_by_zero, hi, lo}, 67'd0);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done) ndone++;
    end
    check("midreset_no_done", 64'(ndone), 64'd0);
    check("midreset_hilo", {hi, lo}, 64'd0);
    run_check("after_reset", 2'b00, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);

    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom();
      rb = $urandom();
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: ra = 32'h8000_0000;
        3: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      model(rop, ra, rb, mh, ml, md);
      run_check($sformatf("rand%0d", n), rop, ra, rb, mh, ml, md);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
# mult_div_unit

- Iterative multiply/divide unit in the EX stage.
- Operands: rs read data on `src_a`, and the ALU B operand (the ALUSrc-selected register or immediate) on `src_b`.
- Computes 32×32→64 products and 32/32 quotient/remainder over 32 cycles, one bit per cycle.
- Results are held in the architectural HI/LO registers, which `mfhi`/`mflo` read and `mthi`/`mtlo` write.
- The control unit stalls the pipeline while `busy` is high.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous, active-low reset
- `start`  in  1  begin operation; sampled only while `busy`=0
- `op`  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- `src_a`  in  32  multiplicand / dividend (rs)
- `src_b`  in  32  multiplier / divisor (ALU B operand)
- `mthi_we`  in  1  write `wdata` into HI
- `mtlo_we`  in  1  write `wdata` into LO
- `wdata`  in  32  mthi/mtlo data
- `busy`  out  1  operation in progress
- `done`  out  1  one-cycle pulse; HI/LO valid
- `div_by_zero`  out  1  qualified by `done`; last divide had `src_b`=0
- `hi`  out  32  HI register
- `lo`  out  32  LO register

## Operation
- FSM states: IDLE, RUN.
- **Reset** (`rst_n`=0 at an edge):
  - State goes to IDLE; iteration counter is cleared.
  - `busy`=0, `done`=0, `div_by_zero`=0, `hi`=0, `lo`=0.
  - Reset taken mid-operation aborts the operation; no result is written.
- **IDLE + `start`=1:**
  - Latch operand magnitudes; `src_b` is captured once and never re-read.
  - Signed ops: magnitude = two's-complement absolute value; latch the result sign (`a[31]^b[31]`) and the remainder sign (`a[31]`).
  - Clear the accumulator and the counter; go to RUN.
- **RUN, multiply:** shift-add on a 64-bit {acc, multiplier} register, one multiplier bit per cycle, LSB first.
- **RUN, divide:** restoring division on a 64-bit {remainder, quotient} register, one quotient bit per cycle, MSB first.
- **Completion:** after 32 RUN cycles (counter = 31), write HI/LO, return to IDLE, pulse `done`.
  - Multiply: {HI,LO} = product. Signed ops negate the 64-bit product if the result sign is set.
  - Divide: LO = quotient, HI = remainder. Signed ops negate the quotient if the result sign is set and the remainder if the remainder sign is set.
  - Outcome: quotient truncates toward zero, remainder takes the sign of the dividend.
- **Divide by zero:**
  - Runs the full 32 cycles; no early exit.
  - Result: LO=0xFFFFFFFF, HI=`src_a` as captured (the signed DIV sign fixup is suppressed).
  - `div_by_zero`=1 alongside `done`.
- **Signed overflow:** DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. No exception is raised.
- **`mthi_we` / `mtlo_we`:**
  - In IDLE they write HI/LO at the edge; both may be asserted together.
  - Ignored in RUN.
  - Ignored in the same cycle as an accepted `start`; `start` wins.
- `start` while `busy`=1 is ignored; no queueing.
- `hi`/`lo` hold their previous values for the whole of RUN and change only at the completion edge.

## Timing
- `start` sampled high at edge E0: `busy`=1 from E0 until E32.
- Edge E32: HI/LO written, `busy`→0, `done`=1 for exactly one cycle (E32 to E33).
- Latency: 32 cycles from start edge to result. The minimum start-to-start interval is 33 cycles; a new `start` may be sampled at E32+1.
- `div_by_zero` is updated only at completion edges and holds until the next completion or reset.
- `done` cannot be high while `busy` is high.

## Configuration
- `MULTDIV_SIGNED_EN` defined:
  - MULT and DIV are signed, as described under Operation.
  - `op[0]` selects signed/unsigned.
- Not defined:
  - `op[0]` is ignored; MULT behaves as MULTU and DIV as DIVU.
  - Sign/magnitude conversion and sign-fixup logic are not built.

## Test plan
- **MULTU:** `src_a`=0xFFFFFFFF, `src_b`=0xFFFFFFFF → after 32 cycles `done`, HI=0xFFFFFFFE, LO=0x00000001.
- **MULT (signed build):** `src_a`=0xFFFFFFFD (−3), `src_b`=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- **DIVU and DIV:**
  - DIVU 100/7 → LO=14, HI=2.
  - DIV −7/2 (signed build) → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- **Divide by zero / overflow:**
  - DIVU 0x1234/0 → LO=0xFFFFFFFF, HI=0x1234, `div_by_zero`=1 with `done`.
  - DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0, `div_by_zero`=0.
- **Handshake:**
  - `start` reasserted at cycles 5 and 31 of RUN → ignored, single `done` at cycle 32.
  - `mthi_we` with `wdata`=0xAAAA5555 during RUN → HI gets the computed result, not the written data.
  - `mtlo_we` with `wdata`=0x5A5A5A5A in IDLE → LO=0x5A5A5A5A next cycle.
- **Reset mid-op:**
  - `rst_n`=0 at cycle 10 of a MULTU → `busy`=0, `done` never pulses, HI=LO=0.
  - A new MULTU 3×5 afterwards → LO=15 after 32 cycles.
